ghost_mode_ctrl: RTL and testbench
==================================

# ghost_mode_ctrl

Frame-rate game-mode controller for an arbitrary number of ghosts. It replaces the combinational eaten-count and pause glue at the top level with a registered state machine. The machine owns four things: the scatter/chase schedule, the frightened timer with its flash warning, the ordered awarding of ghost-eat scores with a freeze per eat, and the death freeze. It runs on the 60 Hz game clock and feeds `pause`, mode and score information to the ghost, pacman and graphics blocks.

## Interface
- NUM_GHOSTS, 4, number of ghost eat inputs (≥2); IW = $clog2(NUM_GHOSTS)
- FRIGHT_FRAMES, 360, frightened duration in frames
- FLASH_FRAMES, 120, final frightened frames with `flash` asserted (< FRIGHT_FRAMES)
- PAUSE_FRAMES, 60, freeze length per awarded ghost eat
- DEATH_FRAMES, 120, freeze length after pacman death
- SCATTER_FRAMES, 420, length of each scatter phase
- CHASE_FRAMES, 1200, length of each non-final chase phase
- NUM_PHASES, 4, scatter/chase pairs before permanent chase (≥1); PW = $clog2(2*NUM_PHASES+1)
- clk  in  1  game clock; one cycle = one frame
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin play (sampled in IDLE only)
- power_pellet  in  1  one-cycle pulse when pacman eats a power pellet
- ghost_eaten  in  NUM_GHOSTS  per-ghost one-cycle pulse when pacman overlaps that ghost
- pacman_dead  in  1  one-cycle pulse when pacman is caught
- pause  out  1  freeze all movers
- frightened  out  1  ghosts in frightened mode
- flash  out  1  frightened and remaining time ≤ FLASH_FRAMES
- chase  out  1  1 = chase, 0 = scatter
- phase  out  PW  current schedule phase index
- score_valid  out  1  one-cycle strobe per awarded eat
- score_add  out  16  points for the award (valid with score_valid)
- eaten_idx  out  IW  award ordinal within the current fright (0 → 200 pts)
- eaten_id  out  IW  index of the ghost being awarded

## Operation
- States:
  - IDLE: pause=1.
  - RUN: normal play.
  - EAT_PAUSE: pause=1.
  - DEATH: pause=1.
- IDLE → RUN on `start`. Entering RUN from IDLE sets phase=0 (scatter) and loads the mode timer with SCATTER_FRAMES.
- Schedule (RUN only, and frozen while `frightened`):
  - The mode timer decrements once per cycle.
  - When it reaches 0, phase increments and the timer reloads: SCATTER_FRAMES for even phases, CHASE_FRAMES for odd phases.
  - When phase = 2*NUM_PHASES, the timer stops and the machine stays in chase permanently.
  - chase = phase[0] | (phase == 2*NUM_PHASES).
- power_pellet in RUN:
  - Loads the fright timer with FRIGHT_FRAMES and sets frightened=1.
  - Clears the eat ordinal and the pending mask.
  - A re-eat while frightened reloads the timer and resets the ordinal.
- Fright timer: decrements each RUN cycle while nonzero and holds in EAT_PAUSE. When it reaches 0, frightened and flash drop. flash = frightened & (timer ≤ FLASH_FRAMES).
- ghost_eaten:
  - OR'd into the pending mask only while frightened; ignored otherwise.
  - In RUN, if pending (including this cycle's bits) is nonzero, serve the lowest set index i:
    - score_valid=1 for one cycle.
    - score_add = 200 << ordinal.
    - eaten_idx = ordinal; eaten_id = i.
    - Clear bit i, ordinal increments (saturating at NUM_GHOSTS-1), go to EAT_PAUSE.
- EAT_PAUSE: counts PAUSE_FRAMES cycles, then serves the next pending bit (staying in EAT_PAUSE) or returns to RUN.
- pacman_dead in RUN → DEATH:
  - Clears frightened, flash, pending mask and ordinal.
  - After DEATH_FRAMES cycles → IDLE.
- Simultaneous events:
  - ghost_eaten while frightened beats pacman_dead; the death is dropped.
  - pacman_dead beats power_pellet.
  - power_pellet together with ghost_eaten: the pellet is applied first; the eat is awarded at ordinal 0.
- power_pellet, pacman_dead and start are ignored in states other than those listed above.
- Widths: each timer is $clog2(max load + 1) bits. score_add is zero-extended; 200 << (NUM_GHOSTS-1) must fit in 16 bits.

## Timing
- All outputs are registered. A response appears on the cycle after the input is sampled.
- Reset (async, rst=0) values:
  - state=IDLE, pause=1.
  - frightened=0, flash=0, chase=0, phase=0.
  - score_valid=0, score_add=0, eaten_idx=0, eaten_id=0.
  - All timers and the pending mask are 0.
- Reset asserted mid-fright or mid-pause aborts immediately to these values. Deassertion is synchronised by the instantiating clock domain.
- score_valid rises in the same cycle as the RUN→EAT_PAUSE transition (pause=1).
- pause stays high for exactly PAUSE_FRAMES cycles per award, back-to-back for queued awards.
- pause stays high for DEATH_FRAMES cycles after a death, then remains high in IDLE.
- Scatter phase 0 lasts exactly SCATTER_FRAMES RUN cycles, excluding frightened and paused cycles.

## Test plan
Bench parameters: NUM_GHOSTS=4, FRIGHT=20, FLASH=5, PAUSE=3, DEATH=6, SCATTER=10, CHASE=15, NUM_PHASES=2.
- Reset, then start, then run 100 cycles with no events → chase toggles 0→1 at cycle 10, 1→0 at 25, 0→1 at 35, and stays 1 from 35 onward; phase ends at 4.
- power_pellet at scatter cycle 4 → frightened for 20 cycles, flash for the last 5; chase stays 0 and scatter completes 6 cycles after fright ends.
- During fright, ghost_eaten=4'b1010 in one cycle → award ghost 1 (200, idx 0) then ghost 3 (400, idx 1); pause high 6 consecutive cycles; fright timer frozen meanwhile.
- Four separate eats in one fright → score_add 200, 400, 800, 1600; a second pellet mid-fright restarts the sequence at 200.
- pacman_dead with ghost_eaten[2] while frightened → award only, no DEATH. pacman_dead alone → pause for 6 cycles, then IDLE, frightened=0.
- rst low during EAT_PAUSE → all outputs immediately at reset values; start then restarts at phase 0.

Source files
------------

// File: rtl/ghost_mode_ctrl.sv
// ghost_mode_ctrl: frame-rate game-mode controller.
// Owns the scatter/chase schedule, the frightened timer with its flash
// warning, ordered ghost-eat scoring with a freeze per award, and the death
// freeze. One clock cycle is one video frame; every output is a register.
module ghost_mode_ctrl #(
  parameter int NUM_GHOSTS     = 4,
  parameter int FRIGHT_FRAMES  = 360,
  parameter int FLASH_FRAMES   = 120,
  parameter int PAUSE_FRAMES   = 60,
  parameter int DEATH_FRAMES   = 120,
  parameter int SCATTER_FRAMES = 420,
  parameter int CHASE_FRAMES   = 1200,
  parameter int NUM_PHASES     = 4,
  localparam int IW = $clog2(NUM_GHOSTS),
  localparam int PW = $clog2(2*NUM_PHASES+1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  power_pellet_i,
  input  logic [NUM_GHOSTS-1:0] ghost_eaten_i,
  input  logic                  pacman_dead_i,
  output logic                  pause_o,
  output logic                  frightened_o,
  output logic                  flash_o,
  output logic                  chase_o,
  output logic [PW-1:0]         phase_o,
  output logic                  score_valid_o,
  output logic [15:0]           score_add_o,
  output logic [IW-1:0]         eaten_idx_o,
  output logic [IW-1:0]         eaten_id_o
);

  localparam int MODE_MAX = (SCATTER_FRAMES > CHASE_FRAMES) ? SCATTER_FRAMES : CHASE_FRAMES;
  localparam int AUX_MAX  = (PAUSE_FRAMES > DEATH_FRAMES) ? PAUSE_FRAMES : DEATH_FRAMES;
  localparam int MTW = $clog2(MODE_MAX + 1);
  localparam int FTW = $clog2(FRIGHT_FRAMES + 1);
  localparam int ATW = $clog2(AUX_MAX + 1);

  localparam logic [MTW-1:0] SCATTER_LOAD = MTW'(SCATTER_FRAMES);
  localparam logic [MTW-1:0] CHASE_LOAD   = MTW'(CHASE_FRAMES);
  localparam logic [FTW-1:0] FRIGHT_LOAD  = FTW'(FRIGHT_FRAMES);
  // Flash is judged on the post-decrement value, hence the +1.
  localparam logic [FTW-1:0] FLASH_EDGE   = FTW'(FLASH_FRAMES + 1);
  localparam logic [ATW-1:0] PAUSE_LOAD   = ATW'(PAUSE_FRAMES);
  localparam logic [ATW-1:0] DEATH_LOAD   = ATW'(DEATH_FRAMES);
  localparam logic [PW-1:0]  LAST_PHASE   = PW'(2*NUM_PHASES);
  localparam logic [IW-1:0]  ORD_MAX      = IW'(NUM_GHOSTS-1);
  localparam logic [15:0]    SCORE_BASE   = 16'd200;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_EAT_PAUSE,
    S_DEATH
  } state_e;

  state_e                state_q;
  logic [MTW-1:0]        mode_tmr_q;
  logic [FTW-1:0]        fright_tmr_q;
  logic [ATW-1:0]        aux_tmr_q;      // shared by eat pause and death freeze
  logic [PW-1:0]         phase_q;
  logic [NUM_GHOSTS-1:0] pending_q;
  logic [IW-1:0]         ordinal_q;
  logic                  frightened_q, flash_q, chase_q, pause_q, score_valid_q;
  logic [15:0]           score_add_q;
  logic [IW-1:0]         eaten_idx_q, eaten_id_q;

  logic                  eat_hit, dead_act, pellet_act, fright_now;
  logic [NUM_GHOSTS-1:0] pending_d, serve_mask;
  logic [IW-1:0]         ordinal_d, ordinal_inc, serve_id;
  logic                  serve_found, do_award;
  logic [PW-1:0]         phase_d;
  logic [15:0]           score_pts;

  // Event arbitration, pending-mask merge and lowest-index award selection.
  always_comb begin
    // NOTE: every combinational output gets a default up front so no path
    // leaves it unassigned, which would otherwise infer a latch.
    serve_found = 1'b0;
    serve_id    = '0;
    eat_hit     = frightened_q & (|ghost_eaten_i);
    dead_act    = (state_q == S_RUN) & pacman_dead_i & ~eat_hit;
    pellet_act  = (state_q == S_RUN) & power_pellet_i & ~dead_act;
    fright_now  = frightened_q | pellet_act;
    pending_d   = (pellet_act ? '0 : pending_q) | (fright_now ? ghost_eaten_i : '0);
    ordinal_d   = pellet_act ? '0 : ordinal_q;
    ordinal_inc = (ordinal_d == ORD_MAX) ? ordinal_d : ordinal_d + 1'b1;
    for (int i = NUM_GHOSTS-1; i >= 0; i--) begin
      if (pending_d[i]) begin
        serve_found = 1'b1;
        serve_id    = IW'(i);
      end
    end
    serve_mask = NUM_GHOSTS'(1) << serve_id;
    do_award   = serve_found &
                 (((state_q == S_RUN) & ~dead_act) |
                  ((state_q == S_EAT_PAUSE) & (aux_tmr_q <= ATW'(1))));
    phase_d    = phase_q + 1'b1;
    score_pts  = SCORE_BASE << ordinal_d;
  end

  // Mode FSM: schedule, fright timer, eat awards and freezes, all registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      mode_tmr_q    <= '0;
      fright_tmr_q  <= '0;
      aux_tmr_q     <= '0;
      phase_q       <= '0;
      pending_q     <= '0;
      ordinal_q     <= '0;
      frightened_q  <= 1'b0;
      flash_q       <= 1'b0;
      chase_q       <= 1'b0;
      pause_q       <= 1'b1;
      score_valid_q <= 1'b0;
      score_add_q   <= '0;
      eaten_idx_q   <= '0;
      eaten_id_q    <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments only; a later assignment
      // in this block deliberately overrides an earlier one (award, death).
      score_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q      <= S_RUN;
            pause_q      <= 1'b0;
            phase_q      <= '0;
            chase_q      <= 1'b0;
            mode_tmr_q   <= SCATTER_LOAD;
            fright_tmr_q <= '0;
            frightened_q <= 1'b0;
            flash_q      <= 1'b0;
            pending_q    <= '0;
            ordinal_q    <= '0;
          end
        end
        S_RUN: begin
          if (!frightened_q && (phase_q != LAST_PHASE)) begin
            if (mode_tmr_q <= MTW'(1)) begin
              phase_q    <= phase_d;
              chase_q    <= phase_d[0] | (phase_d == LAST_PHASE);
              mode_tmr_q <= (phase_d == LAST_PHASE) ? '0 :
                            (phase_d[0] ? CHASE_LOAD : SCATTER_LOAD);
            end else begin
              mode_tmr_q <= mode_tmr_q - 1'b1;
            end
          end
          if (pellet_act) begin
            fright_tmr_q <= FRIGHT_LOAD;
            frightened_q <= 1'b1;
            flash_q      <= 1'b0;
          end else if (fright_tmr_q != '0) begin
            fright_tmr_q <= fright_tmr_q - 1'b1;
            frightened_q <= (fright_tmr_q != FTW'(1));
            flash_q      <= (fright_tmr_q != FTW'(1)) && (fright_tmr_q <= FLASH_EDGE);
          end
          pending_q <= pending_d;
          ordinal_q <= ordinal_d;
          if (dead_act) begin
            state_q      <= S_DEATH;
            pause_q      <= 1'b1;
            aux_tmr_q    <= DEATH_LOAD;
            fright_tmr_q <= '0;
            frightened_q <= 1'b0;
            flash_q      <= 1'b0;
            pending_q    <= '0;
            ordinal_q    <= '0;
          end
        end
        S_EAT_PAUSE: begin
          pending_q <= pending_d;
          if (aux_tmr_q <= ATW'(1)) begin
            state_q <= S_RUN;
            pause_q <= 1'b0;
          end else begin
            aux_tmr_q <= aux_tmr_q - 1'b1;
          end
        end
        S_DEATH: begin
          if (aux_tmr_q <= ATW'(1)) begin
            state_q   <= S_IDLE;
            aux_tmr_q <= '0;
          end else begin
            aux_tmr_q <= aux_tmr_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          pause_q <= 1'b1;
        end
      endcase
      if (do_award) begin
        state_q       <= S_EAT_PAUSE;
        pause_q       <= 1'b1;
        aux_tmr_q     <= PAUSE_LOAD;
        score_valid_q <= 1'b1;
        score_add_q   <= score_pts;
        eaten_idx_q   <= ordinal_d;
        eaten_id_q    <= serve_id;
        ordinal_q     <= ordinal_inc;
        pending_q     <= pending_d & ~serve_mask;
      end
    end
  end

  assign pause_o       = pause_q;
  assign frightened_o  = frightened_q;
  assign flash_o       = flash_q;
  assign chase_o       = chase_q;
  assign phase_o       = phase_q;
  assign score_valid_o = score_valid_q;
  assign score_add_o   = score_add_q;
  assign eaten_idx_o   = eaten_idx_q;
  assign eaten_id_o    = eaten_id_q;

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Directed testbench for ghost_mode_ctrl with small frame counts.
module tb_ghost_mode_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        power_pellet_i = 1'b0;
  logic [3:0]  ghost_eaten_i = '0;
  logic        pacman_dead_i = 1'b0;
  logic        pause_o, frightened_o, flash_o, chase_o, score_valid_o;
  logic [2:0]  phase_o;
  logic [15:0] score_add_o;
  logic [1:0]  eaten_idx_o, eaten_id_o;

  int checks = 0;
  int errors = 0;

  ghost_mode_ctrl #(
    .NUM_GHOSTS(4), .FRIGHT_FRAMES(20), .FLASH_FRAMES(5), .PAUSE_FRAMES(3),
    .DEATH_FRAMES(6), .SCATTER_FRAMES(10), .CHASE_FRAMES(15), .NUM_PHASES(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .power_pellet_i(power_pellet_i), .ghost_eaten_i(ghost_eaten_i),
    .pacman_dead_i(pacman_dead_i), .pause_o(pause_o),
    .frightened_o(frightened_o), .flash_o(flash_o), .chase_o(chase_o),
    .phase_o(phase_o), .score_valid_o(score_valid_o),
    .score_add_o(score_add_o), .eaten_idx_o(eaten_idx_o),
    .eaten_id_o(eaten_id_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame: inputs set before are sampled at this edge; outputs read 1 ns later.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pause"},  32'(pause_o), 1);
    check({tag, "_fright"}, 32'(frightened_o), 0);
    check({tag, "_flash"},  32'(flash_o), 0);
    check({tag, "_chase"},  32'(chase_o), 0);
    check({tag, "_phase"},  32'(phase_o), 0);
    check({tag, "_sv"},     32'(score_valid_o), 0);
    check({tag, "_add"},    32'(score_add_o), 0);
    check({tag, "_idx"},    32'(eaten_idx_o), 0);
    check({tag, "_id"},     32'(eaten_id_o), 0);
  endtask

  // One eat (optionally with pellet/death in the same frame), then its 3-frame pause.
  task automatic award(input string tag, input logic [3:0] g, input logic pel, input logic dead,
                       input logic [15:0] add, input logic [1:0] idx, input logic [1:0] id);
    ghost_eaten_i  = g;
    power_pellet_i = pel;
    pacman_dead_i  = dead;
    cyc();
    ghost_eaten_i  = '0;
    power_pellet_i = 1'b0;
    pacman_dead_i  = 1'b0;
    check({tag, "_sv"},     32'(score_valid_o), 1);
    check({tag, "_add"},    32'(score_add_o), 32'(add));
    check({tag, "_idx"},    32'(eaten_idx_o), 32'(idx));
    check({tag, "_id"},     32'(eaten_id_o), 32'(id));
    check({tag, "_pause"},  32'(pause_o), 1);
    check({tag, "_fright"}, 32'(frightened_o), 1);
    cyc();
    check({tag, "_strobe"}, 32'(score_valid_o), 0);
    cyc();
    check({tag, "_hold"},   32'(pause_o), 1);
    cyc();
    check({tag, "_resume"}, 32'(pause_o), 0);
  endtask

  initial begin
    // Reset
    cyc();
    cyc();
    check_reset_values("reset");
    rst_ni = 1'b1;
    cyc();
    check("idle_pause", 32'(pause_o), 1);

    // Schedule with no events
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    check("start_pause", 32'(pause_o), 0);
    check("start_chase", 32'(chase_o), 0);
    check("start_phase", 32'(phase_o), 0);
    for (int k = 1; k <= 100; k++) begin
      cyc();
      check($sformatf("sched_chase_%0d", k), 32'(chase_o),
            32'((k >= 10 && k < 25) || k >= 35));
      check($sformatf("sched_phase_%0d", k), 32'(phase_o),
            (k < 10) ? 0 : (k < 25) ? 1 : (k < 35) ? 2 : (k < 50) ? 3 : 4);
    end

    // Death from RUN; start ignored until IDLE is reached
    pacman_dead_i = 1'b1;
    cyc();
    pacman_dead_i = 1'b0;
    check("death_pause", 32'(pause_o), 1);
    for (int j = 1; j <= 5; j++) begin
      cyc();
      check($sformatf("death_hold_%0d", j), 32'(pause_o), 1);
    end
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    check("death_start_ignored", 32'(pause_o), 1);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    check("restart_pause", 32'(pause_o), 0);
    check("restart_phase", 32'(phase_o), 0);
    check("restart_chase", 32'(chase_o), 0);

    // Pellet at scatter frame 4: schedule frozen during fright
    cyc();
    cyc();
    cyc();
    power_pellet_i = 1'b1;
    cyc();
    power_pellet_i = 1'b0;
    check("pellet_fright", 32'(frightened_o), 1);
    check("pellet_flash",  32'(flash_o), 0);
    check("pellet_chase",  32'(chase_o), 0);
    for (int k = 5; k <= 31; k++) begin
      cyc();
      check($sformatf("fright_%0d", k), 32'(frightened_o), 32'(k <= 23));
      check($sformatf("flash_%0d", k),  32'(flash_o), 32'(k >= 19 && k <= 23));
      check($sformatf("frz_chase_%0d", k), 32'(chase_o), 32'(k >= 30));
    end
    check("frz_phase", 32'(phase_o), 1);

    // Two ghosts in one frame: queued awards, fright timer frozen while paused
    power_pellet_i = 1'b1;
    cyc();
    power_pellet_i = 1'b0;
    cyc();
    cyc();
    ghost_eaten_i = 4'b1010;
    cyc();
    ghost_eaten_i = '0;
    check("dual_a_sv",  32'(score_valid_o), 1);
    check("dual_a_add", 32'(score_add_o), 200);
    check("dual_a_idx", 32'(eaten_idx_o), 0);
    check("dual_a_id",  32'(eaten_id_o), 1);
    check("dual_a_pause", 32'(pause_o), 1);
    for (int j = 4; j <= 5; j++) begin
      cyc();
      check($sformatf("dual_p_%0d", j),  32'(pause_o), 1);
      check($sformatf("dual_sv_%0d", j), 32'(score_valid_o), 0);
    end
    cyc();
    check("dual_b_sv",  32'(score_valid_o), 1);
    check("dual_b_add", 32'(score_add_o), 400);
    check("dual_b_idx", 32'(eaten_idx_o), 1);
    check("dual_b_id",  32'(eaten_id_o), 3);
    check("dual_b_pause", 32'(pause_o), 1);
    for (int j = 7; j <= 8; j++) begin
      cyc();
      check($sformatf("dual_p_%0d", j),  32'(pause_o), 1);
    end
    cyc();
    check("dual_resume", 32'(pause_o), 0);
    for (int k = 10; k <= 27; k++) begin
      cyc();
      check($sformatf("dual_fright_%0d", k), 32'(frightened_o), 32'(k <= 25));
      check($sformatf("dual_flash_%0d", k),  32'(flash_o), 32'(k >= 21 && k <= 25));
    end
    check("dual_phase", 32'(phase_o), 1);

    // Score doubling, saturation, pellet restart, eat beats death
    power_pellet_i = 1'b1;
    cyc();
    power_pellet_i = 1'b0;
    award("eat1", 4'b0001, 1'b0, 1'b0, 16'd200,  2'd0, 2'd0);
    award("eat2", 4'b0100, 1'b0, 1'b0, 16'd400,  2'd1, 2'd2);
    award("eat3", 4'b1000, 1'b0, 1'b0, 16'd800,  2'd2, 2'd3);
    award("eat4", 4'b0010, 1'b0, 1'b0, 16'd1600, 2'd3, 2'd1);
    award("eat5_sat", 4'b0001, 1'b0, 1'b0, 16'd1600, 2'd3, 2'd0);
    award("repellet", 4'b1000, 1'b1, 1'b0, 16'd200, 2'd0, 2'd3);
    award("reeat",    4'b0010, 1'b0, 1'b0, 16'd400, 2'd1, 2'd1);
    award("eat_vs_dead", 4'b0100, 1'b0, 1'b1, 16'd800, 2'd2, 2'd2);

    // Death while frightened clears fright and ends in IDLE
    pacman_dead_i = 1'b1;
    cyc();
    pacman_dead_i = 1'b0;
    check("dead_pause",  32'(pause_o), 1);
    check("dead_fright", 32'(frightened_o), 0);
    check("dead_flash",  32'(flash_o), 0);
    check("dead_sv",     32'(score_valid_o), 0);
    for (int j = 1; j <= 6; j++) begin
      cyc();
      check($sformatf("dead_hold_%0d", j), 32'(pause_o), 1);
    end
    check("idle_fright", 32'(frightened_o), 0);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    check("start2_pause", 32'(pause_o), 0);

    // Async reset during an eat pause
    power_pellet_i = 1'b1;
    cyc();
    power_pellet_i = 1'b0;
    ghost_eaten_i = 4'b1000;
    cyc();
    ghost_eaten_i = '0;
    check("pre_rst_sv", 32'(score_valid_o), 1);
    check("pre_rst_id", 32'(eaten_id_o), 3);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_values("async_rst");
    cyc();
    rst_ni = 1'b1;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    check("post_rst_pause", 32'(pause_o), 0);
    check("post_rst_fright", 32'(frightened_o), 0);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check($sformatf("post_rst_phase_%0d", k), 32'(phase_o), 32'(k >= 10));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
